// File: rtl/score_display_driver.sv
// Purpose : sync/filter an async 8-bit score, convert to BCD, drive a 4-digit muxed 7-seg display.
// Latency : the 3-flop input sync adds 3 cycles; the FSM takes 1 cycle to capture, 8 to shift and 1 to commit, so digits update on edge 13.
// Backpress: none. Input changes during a conversion are picked up on a later IDLE cycle once the input is stable.
// Ports   : CLK, RESET (async, active-high), SCORE_IN[7:0] (async binary score),
//           SEG_SELECT[3:0] (active-low anodes), HEX_OUT[7:0] ({dp,g..a}, active-low),
//           STROBE[1:0] (lit digit index), BUSY (conversion in flight).
module score_display_driver #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] SCORE_IN,
  output logic [3:0] SEG_SELECT,
  output logic [7:0] HEX_OUT,
  output logic [1:0] STROBE,
  output logic       BUSY
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t        state;
  logic [7:0]    s1, s2, s3;
  logic [7:0]    shown;
  logic [7:0]    cap;
  logic [7:0]    bin_sh;
  logic [11:0]   bcd_sh;
  logic [2:0]    cnt;
  logic [3:0]    hund, tens, ones;
  logic [RW-1:0] rcnt;
  logic          accept;
  logic [11:0]   bcd_adj;
  logic [19:0]   shifted;

  // Two consecutive equal samples (s2/s3) form the glitch filter.
  assign accept = (s2 == s3) && (s2 != shown) && (state == IDLE);

  // Double-dabble step: correct nibbles >= 5 before the shift.
  always_comb begin
    bcd_adj = bcd_sh;
    if (bcd_sh[3:0]  >= 4'd5) bcd_adj[3:0]  = bcd_sh[3:0]  + 4'd3;
    if (bcd_sh[7:4]  >= 4'd5) bcd_adj[7:4]  = bcd_sh[7:4]  + 4'd3;
    if (bcd_sh[11:8] >= 4'd5) bcd_adj[11:8] = bcd_sh[11:8] + 4'd3;
  end

  assign shifted = {bcd_adj, bin_sh} << 1;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1     <= '0;
      s2     <= '0;
      s3     <= '0;
      shown  <= '0;
      cap    <= '0;
      bin_sh <= '0;
      bcd_sh <= '0;
      cnt    <= '0;
      hund   <= '0;
      tens   <= '0;
      ones   <= '0;
      state  <= IDLE;
      BUSY   <= 1'b0;
    end else begin
      s1 <= SCORE_IN;
      s2 <= s1;
      s3 <= s2;
      case (state)
        IDLE: begin
          if (accept) begin
            cap    <= s2;
            bin_sh <= s2;
            bcd_sh <= '0;
            cnt    <= '0;
            state  <= SHIFT;
            BUSY   <= 1'b1;
          end
        end
        SHIFT: begin
          bcd_sh <= shifted[19:8];
          bin_sh <= shifted[7:0];
          cnt    <= cnt + 3'd1;
          if (cnt == 3'd7) state <= COMMIT;
        end
        COMMIT: begin
          hund  <= bcd_sh[11:8];
          tens  <= bcd_sh[7:4];
          ones  <= bcd_sh[3:0];
          shown <= cap;
          state <= IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

  // Digit refresh: each digit stays lit for REFRESH_DIV cycles.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rcnt   <= '0;
      STROBE <= '0;
    end else if (rcnt == RW'(REFRESH_DIV - 1)) begin
      rcnt   <= '0;
      STROBE <= STROBE + 2'd1;
    end else begin
      rcnt <= rcnt + RW'(1);
    end
  end

  function automatic logic [7:0] seg7(input logic [3:0] d, input logic blank);
    logic [7:0] r;
    if (blank) begin
      r = 8'hFF;
    end else begin
      case (d)
        4'd0:    r = 8'hC0;
        4'd1:    r = 8'hF9;
        4'd2:    r = 8'hA4;
        4'd3:    r = 8'hB0;
        4'd4:    r = 8'h99;
        4'd5:    r = 8'h92;
        4'd6:    r = 8'h82;
        4'd7:    r = 8'hF8;
        4'd8:    r = 8'h80;
        4'd9:    r = 8'h90;
        default: r = 8'hFF;
      endcase
    end
    return r;
  endfunction

  logic [3:0] digit;
  logic       blank;

  // Leading-zero blanking: tens blanks only when hundreds is also zero.
  always_comb begin
    digit = '0;
    blank = 1'b1;
    case (STROBE)
      2'd0: begin digit = ones; blank = 1'b0; end
      2'd1: begin digit = tens; blank = (hund == 4'd0) && (tens == 4'd0); end
      2'd2: begin digit = hund; blank = (hund == 4'd0); end
      default: begin digit = '0; blank = 1'b1; end
    endcase
  end

  assign HEX_OUT    = seg7(digit, blank);
  assign SEG_SELECT = ~(4'b0001 << STROBE);

endmodule

// File: tb/tb_score_display_driver.sv
module tb_score_display_driver;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] SCORE_IN = 8'd0;
  logic [3:0] SEG_SELECT;
  logic [7:0] HEX_OUT;
  logic [1:0] STROBE;
  logic       BUSY;

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0] seg_tbl [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [7:0] hex0_tbl [4]   = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] hex105_tbl [4] = '{8'h92, 8'hC0, 8'hF9, 8'hFF};
  logic [7:0] hex42_tbl [4]  = '{8'hA4, 8'h99, 8'hFF, 8'hFF};

  score_display_driver #(.REFRESH_DIV(4)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .SCORE_IN(SCORE_IN),
    .SEG_SELECT(SEG_SELECT),
    .HEX_OUT(HEX_OUT),
    .STROBE(STROBE),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the given digit to be lit, then checks its segments and anode.
  task automatic chk_digit(input string tag, input logic [1:0] s, input logic [7:0] exp);
    int k;
    k = 0;
    while (STROBE !== s && k < 20) begin
      tick(1);
      k++;
    end
    if (STROBE !== s) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s_timeout: observed strobe %0d expected %0d", tag, STROBE, s);
    end else begin
      chk({tag, "_hex"}, HEX_OUT, exp);
      chk({tag, "_sel"}, {4'h0, SEG_SELECT}, {4'h0, seg_tbl[s]});
    end
  endtask

  initial begin
    // Reset state
    tick(3);
    chk("rst_sel", {4'h0, SEG_SELECT}, 8'h0E);
    chk("rst_hex", HEX_OUT, 8'hC0);
    chk("rst_busy", {7'h0, BUSY}, 8'h00);
    chk("rst_strobe", {6'h0, STROBE}, 8'h00);
    RESET = 1'b0;

    // Refresh sweep with score 0: four cycles per digit
    for (int c = 0; c < 16; c++) begin
      chk("sweep_sel", {4'h0, SEG_SELECT}, {4'h0, seg_tbl[c / 4]});
      chk("sweep_hex", HEX_OUT, hex0_tbl[c / 4]);
      tick(1);
    end

    // 0 -> 7: latency profile
    SCORE_IN = 8'd7;
    tick(3);
    chk("s7_busy_e3", {7'h0, BUSY}, 8'h00);
    tick(1);
    chk("s7_busy_e4", {7'h0, BUSY}, 8'h01);
    tick(8);
    chk("s7_busy_e12", {7'h0, BUSY}, 8'h01);
    tick(1);
    chk("s7_busy_e13", {7'h0, BUSY}, 8'h00);
    chk_digit("s7_ones", 2'd0, 8'hF8);
    chk_digit("s7_tens", 2'd1, 8'hFF);
    chk_digit("s7_hund", 2'd2, 8'hFF);

    // 255
    SCORE_IN = 8'd255;
    tick(13);
    chk("s255_busy", {7'h0, BUSY}, 8'h00);
    chk_digit("s255_hund", 2'd2, 8'hA4);
    chk_digit("s255_blank", 2'd3, 8'hFF);
    chk_digit("s255_ones", 2'd0, 8'h92);
    chk_digit("s255_tens", 2'd1, 8'h92);

    // 105, changed to 42 at edge 7
    SCORE_IN = 8'd105;
    tick(6);
    SCORE_IN = 8'd42;
    tick(7);
    chk("s105_busy_e13", {7'h0, BUSY}, 8'h00);
    chk("s105_hex_e13", HEX_OUT, hex105_tbl[STROBE]);
    for (int i = 0; i < 9; i++) begin
      tick(1);
      chk("s42_busy_run", {7'h0, BUSY}, 8'h01);
      chk("s105_hex_hold", HEX_OUT, hex105_tbl[STROBE]);
    end
    tick(1);
    chk("s42_busy_e23", {7'h0, BUSY}, 8'h00);
    chk("s42_hex_e23", HEX_OUT, hex42_tbl[STROBE]);
    chk_digit("s42_ones", 2'd0, 8'hA4);
    chk_digit("s42_tens", 2'd1, 8'h99);
    chk_digit("s42_hund", 2'd2, 8'hFF);

    // Back to 0, then a one-cycle glitch to 9
    SCORE_IN = 8'd0;
    tick(13);
    chk_digit("s0_ones", 2'd0, 8'hC0);
    chk_digit("s0_tens", 2'd1, 8'hFF);
    SCORE_IN = 8'd9;
    tick(1);
    SCORE_IN = 8'd0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("glitch_busy", {7'h0, BUSY}, 8'h00);
    end
    chk_digit("glitch_ones", 2'd0, 8'hC0);

    // 88 with reset at edge 8
    SCORE_IN = 8'd88;
    tick(7);
    chk("s88_busy_e7", {7'h0, BUSY}, 8'h01);
    @(posedge CLK);
    RESET = 1'b1;
    #1;
    chk("s88_rst_busy", {7'h0, BUSY}, 8'h00);
    chk("s88_rst_strobe", {6'h0, STROBE}, 8'h00);
    chk("s88_rst_sel", {4'h0, SEG_SELECT}, 8'h0E);
    chk("s88_rst_hex", HEX_OUT, 8'hC0);
    tick(1);
    RESET = 1'b0;
    tick(4);
    chk("s88_re_busy_e4", {7'h0, BUSY}, 8'h01);
    tick(9);
    chk("s88_re_busy_e13", {7'h0, BUSY}, 8'h00);
    chk_digit("s88_ones", 2'd0, 8'h80);
    chk_digit("s88_tens", 2'd1, 8'h80);
    chk_digit("s88_hund", 2'd2, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
